// File: rtl/adder_io_sequencer_pkg.sv
// Shared definitions for the byte-serial adder front-end: state encoding and byte width.
package io_seq_pkg;

    localparam int BYTE_W = 8;

    // ST_RSVD is never entered on purpose; the FSM sends it back to ST_LOAD.
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_UNLOAD = 2'd2,
        ST_RSVD   = 2'd3
    } state_t;

endpackage

// File: rtl/adder_io_sequencer_if.sv
// Byte streams plus the wide operand/result bus between sequencer and datapath.
// master = sequencer side, slave = pins/datapath side.
interface adder_io_if
    import io_seq_pkg::*;
#(
    parameter int LOG2_BYTES_IN  = 3,
    parameter int LOG2_BYTES_OUT = 2
);
    localparam int OP_W  = (1 << LOG2_BYTES_IN) * BYTE_W;
    localparam int RES_W = (1 << LOG2_BYTES_OUT) * BYTE_W;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   op_data;
    logic [RES_W-1:0]  res_data;
    logic              busy;

    modport master (
        input  in_data, in_valid, out_ready, res_data,
        output in_ready, out_data, out_valid, op_data, busy
    );

    modport slave (
        output in_data, in_valid, out_ready, res_data,
        input  in_ready, out_data, out_valid, op_data, busy
    );

endinterface

// File: rtl/adder_io_sequencer_byte_deserializer.sv
// Collects accepted bytes LSB first into a wide word; byte k lands in lane k.
module byte_deserializer
    import io_seq_pkg::*;
#(
    parameter int LOG2_BYTES = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [BYTE_W-1:0]                    wr_byte,
    output logic                                 last_byte,
    output logic [(1 << LOG2_BYTES)*BYTE_W-1:0]  word
);
    localparam int NBYTES = 1 << LOG2_BYTES;

    logic [LOG2_BYTES-1:0]      in_cnt_r;
    logic [NBYTES-1:0]          lane_we_s;
    logic [NBYTES*BYTE_W-1:0]   word_r;

    // High while the lane about to be written is the top one.
    assign last_byte = (in_cnt_r == {LOG2_BYTES{1'b1}});
    assign word      = word_r;

    // One-hot lane write enable from the current byte position.
    always_comb begin
        lane_we_s = '0;
        if (wr_en) begin
            lane_we_s[in_cnt_r] = 1'b1;
        end else begin
            lane_we_s = '0;
        end
    end

    // Byte position counter, cleared explicitly after the top lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_r <= '0;
        end else if (wr_en) begin
            if (last_byte) begin
                in_cnt_r <= '0;
            end else begin
                in_cnt_r <= in_cnt_r + LOG2_BYTES'(1);
            end
        end
    end

    // Operand lanes; untouched lanes keep their previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r <= '0;
        end else begin
            for (int k = 0; k < NBYTES; k++) begin
                if (lane_we_s[k]) begin
                    word_r[k*BYTE_W +: BYTE_W] <= wr_byte;
                end
            end
        end
    end

endmodule

// File: rtl/adder_io_sequencer.sv
// Byte-serial front-end: load operand bytes, wait out the multicycle datapath,
// capture the result and stream it back LSB byte first.
module adder_io_sequencer
    import io_seq_pkg::*;
#(
    parameter int LOG2_BYTES_IN  = 3,
    parameter int LOG2_BYTES_OUT = 2,
    parameter int EXEC_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    adder_io_if.master bus
);
    localparam int RES_W = (1 << LOG2_BYTES_OUT) * BYTE_W;

    state_t                    state_r;
    state_t                    state_s;
    logic [7:0]                exec_cnt_r;
    logic [LOG2_BYTES_OUT-1:0] out_cnt_r;
    logic [RES_W-1:0]          result_r;
    logic                      in_fire_s;
    logic                      out_fire_s;
    logic                      last_in_s;
    logic                      last_out_s;
    logic                      capture_s;

    assign in_fire_s  = bus.in_valid  && (state_r == ST_LOAD);
    assign out_fire_s = bus.out_ready && (state_r == ST_UNLOAD);
    assign last_out_s = (out_cnt_r == {LOG2_BYTES_OUT{1'b1}});
    assign capture_s  = (state_r == ST_EXEC) && (exec_cnt_r == 8'd1);

    byte_deserializer #(
        .LOG2_BYTES (LOG2_BYTES_IN)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (in_fire_s),
        .wr_byte   (bus.in_data),
        .last_byte (last_in_s),
        .word      (bus.op_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; the unused encoding falls back to LOAD.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (in_fire_s && last_in_s) state_s = ST_EXEC;
                else                        state_s = ST_LOAD;
            end
            ST_EXEC: begin
                if (capture_s) state_s = ST_UNLOAD;
                else           state_s = ST_EXEC;
            end
            ST_UNLOAD: begin
                if (out_fire_s && last_out_s) state_s = ST_LOAD;
                else                          state_s = ST_UNLOAD;
            end
            default: state_s = ST_LOAD;
        endcase
    end

    // Multicycle wait counter, armed by the final operand byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_cnt_r <= 8'd0;
        end else if (in_fire_s && last_in_s) begin
            exec_cnt_r <= 8'(EXEC_CYCLES);
        end else if (state_r == ST_EXEC) begin
            exec_cnt_r <= exec_cnt_r - 8'd1;
        end
    end

    // Result capture at the end of the wait; later res_data changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= '0;
        end else if (capture_s) begin
            result_r <= bus.res_data;
        end
    end

    // Output byte position, cleared explicitly after the top byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_r <= '0;
        end else if (out_fire_s) begin
            if (last_out_s) begin
                out_cnt_r <= '0;
            end else begin
                out_cnt_r <= out_cnt_r + LOG2_BYTES_OUT'(1);
            end
        end
    end

    // Handshake and data outputs decoded purely from registers.
    always_comb begin
        bus.in_ready  = (state_r == ST_LOAD);
        bus.out_valid = (state_r == ST_UNLOAD);
        bus.busy      = (state_r == ST_EXEC) || (state_r == ST_UNLOAD);
        if (state_r == ST_UNLOAD) begin
            bus.out_data = result_r[BYTE_W*out_cnt_r +: BYTE_W];
        end else begin
            bus.out_data = 8'h00;
        end
    end

endmodule

// File: tb/tb_adder_io_sequencer.sv
// Bench: two sequencers (EXEC_CYCLES 2 and 3) fed the same stimulus, each checked
// every cycle against a transaction-level model, plus table vectors and corner sequences.
module tb_adder_io_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data_v;
    logic       in_valid_v;
    logic       out_ready_v;
    logic       force_res;

    int checks;
    int errors;

    adder_io_if #(.LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2)) bus2 ();
    adder_io_if #(.LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2)) bus3 ();

    assign bus2.in_data   = in_data_v;
    assign bus2.in_valid  = in_valid_v;
    assign bus2.out_ready = out_ready_v;
    assign bus2.res_data  = force_res ? 32'hDEADBEEF : bus2.op_data[31:0] + bus2.op_data[63:32];
    assign bus3.in_data   = in_data_v;
    assign bus3.in_valid  = in_valid_v;
    assign bus3.out_ready = out_ready_v;
    assign bus3.res_data  = force_res ? 32'hDEADBEEF : bus3.op_data[31:0] + bus3.op_data[63:32];

    adder_io_sequencer #(.LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2), .EXEC_CYCLES(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.master));
    adder_io_sequencer #(.LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2), .EXEC_CYCLES(3)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3.master));

    logic        rdy_w  [2];
    logic        vld_w  [2];
    logic        busy_w [2];
    logic [7:0]  od_w   [2];
    logic [63:0] op_w   [2];
    assign rdy_w[0]  = bus2.in_ready;   assign rdy_w[1]  = bus3.in_ready;
    assign vld_w[0]  = bus2.out_valid;  assign vld_w[1]  = bus3.out_valid;
    assign busy_w[0] = bus2.busy;       assign busy_w[1] = bus3.busy;
    assign od_w[0]   = bus2.out_data;   assign od_w[1]   = bus3.out_data;
    assign op_w[0]   = bus2.op_data;    assign op_w[1]   = bus3.op_data;

    always #5 clk = ~clk;

    // Reference model: one operation in flight per DUT.
    logic [63:0] m_op   [2];
    int          m_nin  [2];
    bit          m_pend [2];
    int          m_wait [2];
    logic [31:0] m_res  [2];
    int          m_nout [2];
    int          m_exec [2];
    logic [7:0]  got_q[$];

    typedef struct {
        logic [63:0] operand;
        logic [31:0] expected;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h", nm, g, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            m_op[g] = 64'h0; m_nin[g] = 0; m_pend[g] = 1'b0;
            m_wait[g] = 0; m_res[g] = 32'h0; m_nout[g] = 0;
        end
    endtask

    task automatic model_edge(input int g, input bit inf, input logic [7:0] ib,
                              input bit outf, input logic [7:0] ob);
        if (m_pend[g] && !outf) m_wait[g]++;
        if (outf) begin
            chk("out_byte", g, 64'(ob), 64'(m_res[g][8*m_nout[g] +: 8]));
            m_nout[g]++;
            if (m_nout[g] == 4) begin
                m_pend[g] = 1'b0;
                m_nout[g] = 0;
            end
        end
        if (inf) begin
            m_op[g][8*m_nin[g] +: 8] = ib;
            m_nin[g]++;
            if (m_nin[g] == 8) begin
                m_nin[g]  = 0;
                m_pend[g] = 1'b1;
                m_wait[g] = 0;
                m_nout[g] = 0;
                m_res[g]  = m_op[g][31:0] + m_op[g][63:32];
            end
        end
    endtask

    task automatic check_outputs(input int g);
        bit exp_valid;
        exp_valid = m_pend[g] && (m_wait[g] >= m_exec[g]);
        chk("in_ready", g, 64'(rdy_w[g]), 64'(!m_pend[g]));
        chk("busy", g, 64'(busy_w[g]), 64'(m_pend[g]));
        chk("out_valid", g, 64'(vld_w[g]), 64'(exp_valid));
        if (exp_valid) chk("out_data", g, 64'(od_w[g]), 64'(m_res[g][8*m_nout[g] +: 8]));
        chk("op_data", g, op_w[g], m_op[g]);
    endtask

    // Advance one clock: sample handshakes before the edge, update model, check after.
    task automatic step();
        bit         inf  [2];
        bit         outf [2];
        logic [7:0] ob   [2];
        logic [7:0] ib;
        ib = in_data_v;
        for (int g = 0; g < 2; g++) begin
            inf[g]  = in_valid_v && rdy_w[g];
            outf[g] = vld_w[g] && out_ready_v;
            ob[g]   = od_w[g];
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) model_edge(g, inf[g], ib, outf[g], ob[g]);
        if (outf[0]) got_q.push_back(ob[0]);
        for (int g = 0; g < 2; g++) check_outputs(g);
    endtask

    task automatic do_reset();
        in_valid_v  = 1'b0;
        out_ready_v = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        for (int g = 0; g < 2; g++) begin
            check_outputs(g);
            chk("rst_out_data", g, 64'(od_w[g]), 64'h0);
        end
        #1 rst = 1'b0;
    endtask

    task automatic send_bytes(input logic [63:0] operand, input int nbytes);
        int n;
        for (int i = 0; i < nbytes; i++) begin
            n = 0;
            in_valid_v = 1'b0;
            while (!(rdy_w[0] && rdy_w[1]) && n < 100) begin
                step();
                n++;
            end
            if (n >= 100) chk("ready_timeout", 0, 64'd1, 64'd0);
            in_data_v  = operand[8*i +: 8];
            in_valid_v = 1'b1;
            step();
        end
        in_valid_v = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid_v  = 1'b0;
        out_ready_v = 1'b1;
        while ((m_pend[0] || m_pend[1]) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("drain_timeout", 0, 64'd1, 64'd0);
    endtask

    task automatic check_word(input string nm, input logic [31:0] exp);
        logic [31:0] w;
        w = 32'h0;
        chk({nm, "_nbytes"}, 0, 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) w[8*i +: 8] = got_q[i];
        chk(nm, 0, 64'(w), 64'(exp));
    endtask

    initial begin
        int lat2, lat3, n;
        logic [7:0] held;
        clk = 1'b0; rst = 1'b1; in_data_v = 8'h00; in_valid_v = 1'b0;
        out_ready_v = 1'b0; force_res = 1'b0; checks = 0; errors = 0;
        m_exec[0] = 2; m_exec[1] = 3;

        vecs[0] = '{64'h00000002_00000001, 32'h00000003};
        vecs[1] = '{64'h00000001_FFFFFFFF, 32'h00000000};
        vecs[2] = '{64'h80000000_80000000, 32'h00000000};
        vecs[3] = '{64'h12345678_0F0F0F0F, 32'h21436587};
        vecs[4] = '{64'h00000007_00000005, 32'h0000000C};

        @(posedge clk); #1;
        do_reset();

        // Table vectors.
        for (int v = 0; v < 4; v++) begin
            got_q.delete();
            send_bytes(vecs[v].operand, 8);
            drain();
            check_word("vec_sum", vecs[v].expected);
        end

        // Exact latency for both wait settings, then res_data disturbed after capture.
        got_q.delete();
        send_bytes(64'h00000010_00000020, 8);
        out_ready_v = 1'b0;
        lat2 = 0; lat3 = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (vld_w[0] && lat2 == 0) lat2 = k;
            if (vld_w[1] && lat3 == 0) lat3 = k;
        end
        chk("latency", 0, 64'(lat2), 64'd2);
        chk("latency", 1, 64'(lat3), 64'd3);
        force_res = 1'b1;
        step();
        drain();
        check_word("after_capture", 32'h00000030);
        force_res = 1'b0;

        // Backpressure mid-unload.
        got_q.delete();
        send_bytes(64'hA1B2C3D4_01020304, 8);
        out_ready_v = 1'b1;
        n = 0;
        while (got_q.size() < 2 && n < 50) begin step(); n++; end
        out_ready_v = 1'b0;
        held = od_w[0];
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_data", 0, 64'(od_w[0]), 64'(held));
            chk("bp_hold_valid", 0, 64'(vld_w[0]), 64'd1);
        end
        drain();
        check_word("backpressure", 32'hA2B4C6D8);

        // in_valid held high with changing data while both are busy.
        got_q.delete();
        send_bytes(64'h0000_00FF_0000_0001, 8);
        out_ready_v = 1'b1;
        n = 0;
        while (m_pend[0] && m_pend[1] && n < 50) begin
            in_valid_v = 1'b1;
            in_data_v  = 8'($urandom);
            step();
            n++;
        end
        in_valid_v = 1'b0;
        drain();
        check_word("in_ignored", 32'h00000100);

        // Reset after five bytes, then a fresh operation.
        send_bytes(64'h55667788_11223344, 5);
        do_reset();
        got_q.delete();
        send_bytes(vecs[4].operand, 8);
        drain();
        check_word("after_reset", vecs[4].expected);

        // Randomized traffic checked cycle by cycle by the model.
        for (int c = 0; c < 2000; c++) begin
            in_valid_v  = 1'($urandom_range(0, 1));
            in_data_v   = 8'($urandom);
            out_ready_v = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
